// File: rtl/braille_msg_sequencer.sv
// Braille message sequencer: KEY1 captures SW cells, KEY2 replays/stops, KEY3 clears. BRAILLE_LOOP_EN repeats playback.
// Latency: key edge to action is 2 sync + DB_CYCLES + 1 cycles; CELL/CELL_VALID/PLAYING/COUNT/OVF are registered.
// Backpressure: none; each key press is acted on in the cycle it is seen.
module braille_msg_sequencer #(
   parameter int DEPTH     = 16,
   parameter int DWELL     = 50_000_000,
   parameter int GAP       = 12_500_000,
   parameter int DB_CYCLES = 500_000
) (
   input  logic                       CLOCK_50,
   input  logic                       KEY0,
   input  logic                       KEY1,
   input  logic                       KEY2,
   input  logic                       KEY3,
   input  logic [0:5]                 SW,
   output logic [0:5]                 CELL,
   output logic                       CELL_VALID,
   output logic [$clog2(DEPTH+1)-1:0] COUNT,
   output logic                       PLAYING,
   output logic                       OVF
);

   localparam int CW   = $clog2(DEPTH + 1);
   localparam int IW   = $clog2(DEPTH);
   localparam int TMAX = (DWELL > GAP) ? DWELL : GAP;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int DBW  = $clog2(DB_CYCLES + 1);

   localparam logic [TW-1:0]  DWELL_LAST = TW'(DWELL - 1);
   localparam logic [TW-1:0]  GAP_LAST   = TW'(GAP - 1);
   localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
   localparam logic [CW-1:0]  FULL       = CW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

   state_t          state;
   logic [2:0]      key_s1, key_s2;
   logic [0:5]      sw_s1, sw_s2;
   logic [2:0]      db_pressed, press;
   logic [DBW-1:0]  db_cnt [3];
   logic [0:5]      cell_mem [DEPTH];
   logic [IW-1:0]   idx;
   logic [TW-1:0]   timer;
   logic [CW-1:0]   nxt;
   logic            wr_en;

   always_ff @(posedge CLOCK_50) begin
      if (!KEY0) begin
         key_s1 <= '1;
         key_s2 <= '1;
         sw_s1  <= '0;
         sw_s2  <= '0;
      end else begin
         key_s1 <= {KEY3, KEY2, KEY1};
         key_s2 <= key_s1;
         sw_s1  <= SW;
         sw_s2  <= sw_s1;
      end
   end

   // Debounced level flips only after DB_CYCLES samples disagreeing with it; press pulses on the flip to pressed.
   always_ff @(posedge CLOCK_50) begin
      if (!KEY0) begin
         db_pressed <= '0;
         press      <= '0;
         for (int k = 0; k < 3; k++) db_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            press[k] <= 1'b0;
            if (!key_s2[k] == db_pressed[k]) begin
               db_cnt[k] <= '0;
            end else if (db_cnt[k] == DB_LAST) begin
               db_cnt[k]     <= '0;
               db_pressed[k] <= ~db_pressed[k];
               press[k]      <= ~db_pressed[k];
            end else begin
               db_cnt[k] <= db_cnt[k] + DBW'(1);
            end
         end
      end
   end

   assign wr_en = (state == S_IDLE) && press[0] && !press[1] && !press[2] && (COUNT != FULL);
   assign nxt   = CW'(idx) + CW'(1);

   always_ff @(posedge CLOCK_50) begin
      if (wr_en) cell_mem[COUNT[IW-1:0]] <= sw_s2;
   end

   always_ff @(posedge CLOCK_50) begin
      if (!KEY0) begin
         state      <= S_IDLE;
         CELL       <= '0;
         CELL_VALID <= 1'b0;
         COUNT      <= '0;
         PLAYING    <= 1'b0;
         OVF        <= 1'b0;
         idx        <= '0;
         timer      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (press[2]) begin
                  COUNT <= '0;
                  OVF   <= 1'b0;
               end else if (press[1]) begin
                  if (COUNT != '0) begin
                     idx        <= '0;
                     timer      <= '0;
                     state      <= S_PLAY;
                     PLAYING    <= 1'b1;
                     CELL       <= cell_mem[0];
                     CELL_VALID <= 1'b1;
                  end
               end else if (press[0]) begin
                  if (COUNT == FULL) OVF <= 1'b1;
                  else               COUNT <= COUNT + CW'(1);
               end
            end
            default: begin
               if (press[1]) begin
                  state      <= S_IDLE;
                  PLAYING    <= 1'b0;
                  CELL       <= '0;
                  CELL_VALID <= 1'b0;
                  timer      <= '0;
               end else if (state == S_PLAY) begin
                  if (timer == DWELL_LAST) begin
                     timer      <= '0;
                     state      <= S_GAP;
                     CELL       <= '0;
                     CELL_VALID <= 1'b0;
                  end else begin
                     timer <= timer + TW'(1);
                  end
               end else if (timer == GAP_LAST) begin
                  timer <= '0;
                  if (nxt < COUNT) begin
                     idx        <= nxt[IW-1:0];
                     state      <= S_PLAY;
                     CELL       <= cell_mem[nxt[IW-1:0]];
                     CELL_VALID <= 1'b1;
                  end else begin
`ifdef BRAILLE_LOOP_EN
                     idx        <= '0;
                     state      <= S_PLAY;
                     CELL       <= cell_mem[0];
                     CELL_VALID <= 1'b1;
`else
                     state      <= S_IDLE;
                     PLAYING    <= 1'b0;
`endif
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_braille_msg_sequencer.sv
// Directed bench for braille_msg_sequencer: capture/overflow/clear model plus a playback scoreboard
// that pops expected cells as they appear and checks dwell and gap lengths.
module tb_braille_msg_sequencer;

   localparam int DEPTH = 4;
   localparam int DWELL = 8;
   localparam int GAP   = 2;
   localparam int DB    = 3;

   logic       clk = 1'b0;
   logic       KEY0, KEY1, KEY2, KEY3;
   logic [0:5] SW;
   logic [0:5] CELL;
   logic       CELL_VALID;
   logic [2:0] COUNT;
   logic       PLAYING;
   logic       OVF;

   int checks   = 0;
   int failures = 0;

   logic [0:5] mdl [$];
   bit         mdl_ovf;
   logic [0:5] exp_q [$];
   bit         allow_extra = 1'b0;
   bit         mon_on = 1'b0;

   braille_msg_sequencer #(.DEPTH(DEPTH), .DWELL(DWELL), .GAP(GAP), .DB_CYCLES(DB)) dut (
      .CLOCK_50(clk), .KEY0(KEY0), .KEY1(KEY1), .KEY2(KEY2), .KEY3(KEY3), .SW(SW),
      .CELL(CELL), .CELL_VALID(CELL_VALID), .COUNT(COUNT), .PLAYING(PLAYING), .OVF(OVF)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_key(input int k, input logic v);
      case (k)
         1: KEY1 = v;
         2: KEY2 = v;
         default: KEY3 = v;
      endcase
   endtask

   task automatic press(input int k);
      set_key(k, 1'b0);
      tick(8);
      set_key(k, 1'b1);
      tick(8);
   endtask

   task automatic capture(input logic [0:5] c);
      SW = c;
      press(1);
      if (mdl.size() < DEPTH) mdl.push_back(c);
      else mdl_ovf = 1'b1;
   endtask

   task automatic wait_playing(input logic v, input string tag);
      int n = 0;
      while (PLAYING !== v && n < 300) begin @(negedge clk); n++; end
      check(tag, PLAYING, v);
   endtask

   task automatic wait_valid(input logic v, input string tag);
      int n = 0;
      while (CELL_VALID !== v && n < 300) begin @(negedge clk); n++; end
      check(tag, CELL_VALID, v);
   endtask

   task automatic wait_qsize(input int s, input string tag);
      int n = 0;
      while (exp_q.size() != s && n < 300) begin @(negedge clk); n++; end
      check(tag, exp_q.size(), s);
   endtask

   // Playback monitor: pops one expected cell per rising CELL_VALID, times dwell and gap phases.
   logic prev_valid = 1'b0, prev_playing = 1'b0;
   int   run_len = 0, gap_len = 0;
   always @(negedge clk) begin
      if (mon_on) begin
         if (PLAYING === 1'b1 && CELL_VALID === 1'b0) gap_len++;
         if (CELL_VALID === 1'b0) check("cell_zero_when_invalid", CELL, 6'b0);
         if (CELL_VALID === 1'b1 && !prev_valid) begin
            check("cell_expected", (exp_q.size() > 0) || allow_extra, 1'b1);
            if (exp_q.size() > 0) check("cell_value", CELL, exp_q.pop_front());
            if (gap_len != 0) check("gap_len", gap_len, GAP);
            run_len = 1;
            gap_len = 0;
         end else if (CELL_VALID === 1'b1) begin
            run_len++;
         end
         if (CELL_VALID === 1'b0 && prev_valid && PLAYING === 1'b1)
            check("dwell_len", run_len, DWELL);
         if (PLAYING === 1'b0 && prev_playing && !prev_valid)
            check("last_gap_len", gap_len, GAP);
         if (PLAYING !== 1'b1) gap_len = 0;
         prev_valid   = (CELL_VALID === 1'b1);
         prev_playing = (PLAYING === 1'b1);
      end
   end

   initial begin
      KEY0 = 1'b0; KEY1 = 1'b1; KEY2 = 1'b1; KEY3 = 1'b1; SW = '0;
      mdl_ovf = 1'b0;
      tick(3);
      @(negedge clk);
      check("rst_cell", CELL, 6'b0);
      check("rst_valid", CELL_VALID, 1'b0);
      check("rst_count", COUNT, 3'd0);
      check("rst_playing", PLAYING, 1'b0);
      check("rst_ovf", OVF, 1'b0);
      mon_on = 1'b1;
      KEY0 = 1'b1;
      tick(2);

      // Two-cycle glitch must not survive the debouncer
      SW = 6'b100000;
      KEY1 = 1'b0;
      tick(2);
      KEY1 = 1'b1;
      tick(10);
      check("glitch_count", COUNT, 3'd0);

      capture(6'b100000);
      capture(6'b110000);
      capture(6'b100100);
      check("cap3_count", COUNT, mdl.size());

`ifdef BRAILLE_LOOP_EN
      foreach (mdl[i]) exp_q.push_back(mdl[i]);
      exp_q.push_back(mdl[0]);
      press(2);
      wait_qsize(0, "loop_wrap_seen");
      allow_extra = 1'b1;
      press(2);
      wait_playing(1'b0, "loop_stopped");
      allow_extra = 1'b0;
`else
      foreach (mdl[i]) exp_q.push_back(mdl[i]);
      press(2);
      wait_playing(1'b1, "play_started");
      wait_playing(1'b0, "play_ended");
      check("play_drained", exp_q.size(), 0);
`endif
      check("play_count_kept", COUNT, mdl.size());

      press(3);
      mdl.delete();
      mdl_ovf = 1'b0;
      check("clear_count", COUNT, mdl.size());
      capture(6'b101010);
      capture(6'b010101);
      capture(6'b111111);
      capture(6'b000001);
      capture(6'b110011);
      check("full_count", COUNT, mdl.size());
      check("full_ovf", OVF, mdl_ovf);
      press(3);
      mdl.delete();
      mdl_ovf = 1'b0;
      check("clear2_count", COUNT, mdl.size());
      check("clear2_ovf", OVF, mdl_ovf);
      press(2);
      tick(4);
      check("empty_play_playing", PLAYING, 1'b0);
      check("empty_play_valid", CELL_VALID, 1'b0);

      // Stop during the second cell's dwell
      capture(6'b011000);
      capture(6'b000110);
      capture(6'b100001);
      check("cap_b_count", COUNT, mdl.size());
      exp_q.push_back(mdl[0]);
      exp_q.push_back(mdl[1]);
      KEY2 = 1'b0;
      wait_qsize(1, "stop_c0_seen");
      KEY2 = 1'b1;
      wait_valid(1'b0, "stop_c0_done");
      KEY2 = 1'b0;
      wait_qsize(0, "stop_c1_seen");
      wait_playing(1'b0, "stop_idle");
      check("stop_valid", CELL_VALID, 1'b0);
      check("stop_cell", CELL, 6'b0);
      check("stop_count_kept", COUNT, mdl.size());
      KEY2 = 1'b1;
      tick(10);

      // Reset while a cell is being shown
      exp_q.push_back(mdl[0]);
      KEY2 = 1'b0;
      wait_qsize(0, "rst_play_c0_seen");
      KEY0 = 1'b0;
      KEY2 = 1'b1;
      @(negedge clk);
      mdl.delete();
      mdl_ovf = 1'b0;
      check("midrst_playing", PLAYING, 1'b0);
      check("midrst_valid", CELL_VALID, 1'b0);
      check("midrst_cell", CELL, 6'b0);
      check("midrst_count", COUNT, mdl.size());
      check("midrst_ovf", OVF, mdl_ovf);
      KEY0 = 1'b1;
      tick(10);
      check("midrst_stays_idle", PLAYING, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
